// File: rtl/cape_job_sched_if.sv
// rtl/cape_job_sched_if.sv - Job request/response port of the CAPE SNG job scheduler
// The master is the job dispatcher; the slave is the scheduler.
interface cape_job_sched_if #(
   parameter int WIDTH      = 4,
   parameter int NUM_INPUTS = 2
) ();
   localparam int CW = WIDTH*NUM_INPUTS+1;
   localparam int PW = $clog2(WIDTH+1);

   logic                          req_valid;
   logic                          req_ready;
   logic [WIDTH*NUM_INPUTS-1:0]   req_bxs;
   logic [PW-1:0]                 req_prec;
   logic                          abort;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [CW-1:0]                 rsp_count;
   logic [CW-1:0]                 rsp_cycles;
   logic [1:0]                    rsp_status;

   modport master (
      output req_valid, req_bxs, req_prec, abort, rsp_ready,
      input  req_ready, rsp_valid, rsp_count, rsp_cycles, rsp_status
   );

   modport slave (
      input  req_valid, req_bxs, req_prec, abort, rsp_ready,
      output req_ready, rsp_valid, rsp_count, rsp_cycles, rsp_status
   );
endinterface

// File: rtl/cape_job_sched.sv
// rtl/cape_job_sched.sv - Job scheduler sequencing one shared CAPE stochastic number generator
// Loads operands and truncation mask, restarts the SNG, counts all-ones cycles until period end.
module cape_job_sched #(
   parameter int WIDTH      = 4,
   parameter int NUM_INPUTS = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   cape_job_sched_if.slave             job,
   output logic                        sng_clr_n,
   output logic [WIDTH*NUM_INPUTS-1:0] sng_bxs,
   output logic [WIDTH-1:0]            sng_trunc,
   input  logic [NUM_INPUTS-1:0]       sng_xs,
   input  logic                        sng_done,
   output logic                        busy
);
   localparam int CW = WIDTH*NUM_INPUTS+1;
   localparam int PW = $clog2(WIDTH+1);
   localparam logic [PW-1:0] PREC_MAX  = PW'(WIDTH);
   // Timeout limit is 2^(WIDTH*NUM_INPUTS), i.e. only the counter MSB set.
   localparam logic [CW-1:0] CYC_LIMIT = {1'b1, {(CW-1){1'b0}}};
   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_ABORT   = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

   state_t                      state_q, state_d;
   logic                        sng_clr_n_q, sng_clr_n_d;
   logic [WIDTH*NUM_INPUTS-1:0] sng_bxs_q, sng_bxs_d;
   logic [WIDTH-1:0]            sng_trunc_q, sng_trunc_d;
   logic [CW-1:0]               count_q, count_d;
   logic [CW-1:0]               cycles_q, cycles_d;
   logic [1:0]                  status_q, status_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic [PW-1:0]               prec_eff;
   logic [WIDTH-1:0]            trunc_dec;

   always_comb begin
      prec_eff = job.req_prec;
      if (job.req_prec == '0 || job.req_prec > PREC_MAX) prec_eff = PREC_MAX;
      trunc_dec = '0;
      for (int k = 0; k < WIDTH; k++) trunc_dec[k] = (k < (WIDTH - int'(prec_eff)));
   end

   always_comb begin
      state_d     = state_q;
      sng_clr_n_d = 1'b1;
      sng_bxs_d   = sng_bxs_q;
      sng_trunc_d = sng_trunc_q;
      count_d     = count_q;
      cycles_d    = cycles_q;
      status_d    = status_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         S_IDLE: begin
            if (job.req_valid) begin
               sng_bxs_d   = job.req_bxs;
               sng_trunc_d = trunc_dec;
               count_d     = '0;
               cycles_d    = '0;
               sng_clr_n_d = 1'b0;
               state_d     = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (job.abort) begin
               status_d    = ST_ABORT;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Period end outranks abort so a job finishing on the abort cycle still reports ok.
            if (sng_done) begin
               status_d    = ST_OK;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (job.abort) begin
               status_d    = ST_ABORT;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (cycles_q == CYC_LIMIT) begin
               status_d    = ST_TIMEOUT;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cycles_d = cycles_q + CW'(1);
               count_d  = count_q + {{(CW-1){1'b0}}, &sng_xs};
            end
         end
         S_RESP: begin
            if (job.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sng_clr_n_q <= 1'b1;
         sng_bxs_q   <= '0;
         sng_trunc_q <= '0;
         count_q     <= '0;
         cycles_q    <= '0;
         status_q    <= ST_OK;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sng_clr_n_q <= sng_clr_n_d;
         sng_bxs_q   <= sng_bxs_d;
         sng_trunc_q <= sng_trunc_d;
         count_q     <= count_d;
         cycles_q    <= cycles_d;
         status_q    <= status_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign sng_clr_n      = sng_clr_n_q;
   assign sng_bxs        = sng_bxs_q;
   assign sng_trunc      = sng_trunc_q;
   assign job.req_ready  = (state_q == S_IDLE);
   assign busy           = (state_q != S_IDLE);
   assign job.rsp_valid  = rsp_valid_q;
   assign job.rsp_count  = count_q;
   assign job.rsp_cycles = cycles_q;
   assign job.rsp_status = status_q;
endmodule

// File: tb/tb_cape_job_sched.sv
// tb/tb_cape_job_sched.sv - Self-checking bench for cape_job_sched
// Behavioural SNG plus a stream-level reference model of count, cycles, status and latency.
module tb_cape_job_sched;
   localparam int W = 4;
   localparam int N = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sng_clr_n;
   logic [7:0] sng_bxs;
   logic [3:0] sng_trunc;
   logic [1:0] sng_xs;
   logic       sng_done;
   logic       busy;
   bit         hold_done = 1'b0;
   int         sng_cnt;
   int         sng_p;
   int         sng_per;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   cape_job_sched_if #(.WIDTH(W), .NUM_INPUTS(N)) job ();

   cape_job_sched #(.WIDTH(W), .NUM_INPUTS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .job       (job),
      .sng_clr_n (sng_clr_n),
      .sng_bxs   (sng_bxs),
      .sng_trunc (sng_trunc),
      .sng_xs    (sng_xs),
      .sng_done  (sng_done),
      .busy      (busy)
   );

   // Behavioural SNG: lane i compares its kept MSBs against digit i of a shared counter.
   always_comb begin
      sng_xs  = '0;
      sng_p   = W - $countones(sng_trunc);
      sng_per = 1 << (N * sng_p);
      for (int i = 0; i < N; i++)
         sng_xs[i] = (int'(sng_bxs[i*W +: W]) >> (W - sng_p)) > ((sng_cnt >> (i * sng_p)) & ((1 << sng_p) - 1));
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || !sng_clr_n) begin
         sng_cnt  <= 0;
         sng_done <= 1'b0;
      end else begin
         sng_cnt  <= (sng_cnt == sng_per - 1) ? 0 : sng_cnt + 1;
         sng_done <= !hold_done && (sng_cnt == sng_per - 1);
      end
   end

   function automatic int eff_prec(input int prec);
      return (prec == 0 || prec > W) ? W : prec;
   endfunction

   function automatic int period(input int prec);
      return 1 << (N * eff_prec(prec));
   endfunction

   function automatic int level(input logic [7:0] bxs, input int lane, input int prec);
      int p = eff_prec(prec);
      return (int'(bxs) / (1 << (lane * W)) % (1 << W)) / (1 << (W - p));
   endfunction

   // Number of the first len stream positions where every lane's level beats its counter digit.
   function automatic int ref_count(input logic [7:0] bxs, input int prec, input int len);
      int p = eff_prec(prec);
      int hits = 0;
      for (int c = 0; c < len; c++) begin
         int ph = c % period(prec);
         bit all1 = 1'b1;
         for (int i = 0; i < N; i++)
            if (level(bxs, i, prec) <= (ph / (1 << (i * p))) % (1 << p)) all1 = 1'b0;
         hits += int'(all1);
      end
      return hits;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input logic [7:0] bxs, input int prec, input int abort_at, input bit hd,
                          output int lat, output int cnt, output int cyc, output int st);
      int n = 0;
      hold_done = hd;
      while (!job.req_ready && n < 20) begin
         tick();
         n++;
      end
      job.req_bxs   = bxs;
      job.req_prec  = 3'(prec);
      job.req_valid = 1'b1;
      tick();
      job.req_valid = 1'b0;
      n = 1;
      while (!job.rsp_valid && n < 600) begin
         job.abort = (n == abort_at);
         tick();
         n++;
      end
      job.abort = 1'b0;
      if (!job.rsp_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_wait: got no rsp_valid after %0d cycles, required within 600", n);
      end
      lat = n;
      cnt = int'(job.rsp_count);
      cyc = int'(job.rsp_cycles);
      st  = int'(job.rsp_status);
   endtask

   task automatic finish_rsp();
      job.rsp_ready = 1'b1;
      tick();
      job.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({job.req_ready, sng_clr_n, sng_bxs, sng_trunc, job.rsp_valid, busy} !== {1'b1, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy=%0b clr_n=%0b bxs=%0h trunc=%0h vld=%0b busy=%0b, required 1 1 0 0 0 0",
                  job.req_ready, sng_clr_n, sng_bxs, sng_trunc, job.rsp_valid, busy);
      end
      n_checks++;
      if ({job.rsp_count, job.rsp_cycles, job.rsp_status} !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: got count=%0d cycles=%0d status=%0d, required 0 0 0",
                  job.rsp_count, job.rsp_cycles, job.rsp_status);
      end
   endtask

   task automatic test_full_precision();
      int lat, cnt, cyc, st;
      run_job(8'h88, 4, -1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (cyc !== 256 || cnt !== 64 || st !== 0) begin
         n_fail++;
         $display("FAIL full_result: got cycles=%0d count=%0d status=%0d, required 256 64 0", cyc, cnt, st);
      end
      n_checks++;
      if (lat !== 259) begin
         n_fail++;
         $display("FAIL full_latency: got %0d, required 259", lat);
      end
      n_checks++;
      if (sng_bxs !== 8'h88 || sng_trunc !== 4'h0 || busy !== 1'b1 || job.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_sng_out: got bxs=%0h trunc=%0h busy=%0b rdy=%0b, required 88 0 1 0",
                  sng_bxs, sng_trunc, busy, job.req_ready);
      end
      finish_rsp();
   endtask

   task automatic test_zero_operand();
      int lat, cnt, cyc, st;
      run_job(8'h0F, 4, -1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (cnt !== 0 || cyc !== 256) begin
         n_fail++;
         $display("FAIL zero_operand: got count=%0d cycles=%0d, required 0 256", cnt, cyc);
      end
      finish_rsp();
      run_job(8'hFF, 4, -1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (cnt !== 225 || cyc !== 256) begin
         n_fail++;
         $display("FAIL max_operand: got count=%0d cycles=%0d, required 225 256", cnt, cyc);
      end
      finish_rsp();
   endtask

   task automatic test_early_term();
      int lat, cnt, cyc, st;
      run_job(8'h48, 2, -1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (sng_trunc !== 4'b0011) begin
         n_fail++;
         $display("FAIL trunc_prec2: got %b, required 0011", sng_trunc);
      end
      n_checks++;
      if (cyc >= 256 || cnt * 256 !== cyc * 32 || cyc !== 16 || lat !== 19 || st !== 0) begin
         n_fail++;
         $display("FAIL early_term: got cycles=%0d count=%0d lat=%0d status=%0d, required 16 2 19 0", cyc, cnt, lat, st);
      end
      finish_rsp();
      run_job(8'h88, 0, -1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (sng_trunc !== 4'h0 || cyc !== 256 || cnt !== 64) begin
         n_fail++;
         $display("FAIL prec0: got trunc=%b cycles=%0d count=%0d, required 0000 256 64", sng_trunc, cyc, cnt);
      end
      finish_rsp();
   endtask

   task automatic test_abort();
      int lat, cnt, cyc, st;
      logic [7:0] bxs = 8'($urandom);
      run_job(bxs, 4, 12, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (st !== 1 || cyc !== 10 || cnt !== ref_count(bxs, 4, 10) || lat !== 13) begin
         n_fail++;
         $display("FAIL abort_run: got status=%0d cycles=%0d count=%0d lat=%0d, required 1 10 %0d 13",
                  st, cyc, cnt, lat, ref_count(bxs, 4, 10));
      end
      finish_rsp();
      run_job(bxs, 2, 18, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (st !== 0 || cyc !== 16 || cnt !== level(bxs, 0, 2) * level(bxs, 1, 2)) begin
         n_fail++;
         $display("FAIL abort_with_done: got status=%0d cycles=%0d count=%0d, required 0 16 %0d",
                  st, cyc, cnt, level(bxs, 0, 2) * level(bxs, 1, 2));
      end
      finish_rsp();
      run_job(bxs, 3, 1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (st !== 1 || cyc !== 0 || cnt !== 0 || lat !== 2) begin
         n_fail++;
         $display("FAIL abort_clear: got status=%0d cycles=%0d count=%0d lat=%0d, required 1 0 0 2", st, cyc, cnt, lat);
      end
      finish_rsp();
   endtask

   task automatic test_timeout();
      int lat, cnt, cyc, st;
      int prec = $urandom_range(1, 4);
      logic [7:0] bxs = 8'($urandom);
      run_job(bxs, prec, -1, 1'b1, lat, cnt, cyc, st);
      n_checks++;
      if (st !== 2 || cyc !== 256 || lat !== 259 || cnt !== ref_count(bxs, prec, 256)) begin
         n_fail++;
         $display("FAIL timeout: got status=%0d cycles=%0d lat=%0d count=%0d, required 2 256 259 %0d",
                  st, cyc, lat, cnt, ref_count(bxs, prec, 256));
      end
      finish_rsp();
      hold_done = 1'b0;
   endtask

   task automatic test_rsp_hold();
      int lat, cnt, cyc, st;
      logic [7:0] bxs = 8'($urandom);
      int exp_cnt = level(bxs, 0, 3) * level(bxs, 1, 3);
      run_job(bxs, 3, -1, 1'b0, lat, cnt, cyc, st);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (job.rsp_valid !== 1'b1 || job.req_ready !== 1'b0 || int'(job.rsp_count) !== exp_cnt ||
             int'(job.rsp_cycles) !== 64 || job.rsp_status !== 2'd0) begin
            n_fail++;
            $display("FAIL rsp_hold[%0d]: got vld=%0b rdy=%0b count=%0d cycles=%0d status=%0d, required 1 0 %0d 64 0",
                     i, job.rsp_valid, job.req_ready, job.rsp_count, job.rsp_cycles, job.rsp_status, exp_cnt);
         end
         tick();
      end
      finish_rsp();
   endtask

   task automatic test_back_to_back();
      int lat, cnt, cyc, st;
      int n = 0;
      run_job(8'hA5, 1, -1, 1'b0, lat, cnt, cyc, st);
      job.rsp_ready = 1'b1;
      job.req_valid = 1'b1;
      job.req_bxs   = 8'h9C;
      job.req_prec  = 3'd4;
      n_checks++;
      if (job.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_rdy_in_resp: got %0b, required 0", job.req_ready);
      end
      tick();
      job.rsp_ready = 1'b0;
      n_checks++;
      if (job.req_ready !== 1'b1 || job.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_bubble: got rdy=%0b vld=%0b, required 1 0", job.req_ready, job.rsp_valid);
      end
      tick();
      job.req_valid = 1'b0;
      n_checks++;
      if (sng_clr_n !== 1'b0 || busy !== 1'b1 || sng_bxs !== 8'h9C) begin
         n_fail++;
         $display("FAIL b2b_accept: got clr_n=%0b busy=%0b bxs=%0h, required 0 1 9c", sng_clr_n, busy, sng_bxs);
      end
      while (!job.rsp_valid && n < 600) begin
         tick();
         n++;
      end
      n_checks++;
      if (int'(job.rsp_count) !== 9 * 12 || int'(job.rsp_cycles) !== 256 || n !== 258) begin
         n_fail++;
         $display("FAIL b2b_second: got count=%0d cycles=%0d wait=%0d, required 108 256 258",
                  job.rsp_count, job.rsp_cycles, n);
      end
      finish_rsp();
   endtask

   task automatic test_reset_mid_run();
      int lat, cnt, cyc, st;
      job.req_bxs   = 8'h77;
      job.req_prec  = 3'd4;
      job.req_valid = 1'b1;
      tick();
      job.req_valid = 1'b0;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      test_reset();
      tick();
      rst_n = 1'b1;
      tick();
      run_job(8'h6B, 4, -1, 1'b0, lat, cnt, cyc, st);
      n_checks++;
      if (cnt !== 66 || cyc !== 256 || st !== 0 || lat !== 259) begin
         n_fail++;
         $display("FAIL after_reset: got count=%0d cycles=%0d status=%0d lat=%0d, required 66 256 0 259", cnt, cyc, st, lat);
      end
      finish_rsp();
   endtask

   task automatic test_random();
      for (int j = 0; j < 12; j++) begin
         int lat, cnt, cyc, st;
         int e_lat, e_cnt, e_cyc, e_st, abort_at, k;
         logic [7:0] bxs = 8'($urandom);
         int prec = $urandom_range(0, 7);
         int per = period(prec);
         int mode = $urandom_range(0, 3);
         abort_at = -1;
         e_cyc = per;
         e_st  = 0;
         e_lat = per + 3;
         if (mode == 2) begin
            k        = $urandom_range(0, per - 1);
            abort_at = k + 2;
            e_cyc    = k;
            e_st     = 1;
            e_lat    = k + 3;
         end else if (mode == 3) begin
            abort_at = 1;
            e_cyc    = 0;
            e_st     = 1;
            e_lat    = 2;
         end
         e_cnt = ref_count(bxs, prec, e_cyc);
         run_job(bxs, prec, abort_at, 1'b0, lat, cnt, cyc, st);
         n_checks++;
         if (cnt !== e_cnt || cyc !== e_cyc || st !== e_st || lat !== e_lat) begin
            n_fail++;
            $display("FAIL random[%0d] bxs=%0h prec=%0d mode=%0d: got count=%0d cycles=%0d status=%0d lat=%0d, required %0d %0d %0d %0d",
                     j, bxs, prec, mode, cnt, cyc, st, lat, e_cnt, e_cyc, e_st, e_lat);
         end
         n_checks++;
         if (int'(sng_trunc) !== (1 << (W - eff_prec(prec))) - 1 || sng_bxs !== bxs) begin
            n_fail++;
            $display("FAIL random_sng[%0d]: got trunc=%b bxs=%0h, required prec %0d bxs %0h",
                     j, sng_trunc, sng_bxs, eff_prec(prec), bxs);
         end
         repeat ($urandom_range(0, 3)) tick();
         finish_rsp();
      end
   endtask

   initial begin
      job.req_valid = 1'b0;
      job.req_bxs   = '0;
      job.req_prec  = '0;
      job.abort     = 1'b0;
      job.rsp_ready = 1'b0;
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_full_precision();
      test_zero_operand();
      test_early_term();
      test_abort();
      test_timeout();
      test_rsp_hold();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cape_job_sched.md
# cape_job_sched

Job scheduler that sequences one shared CAPE-style stochastic number generator with early-termination support, the SNG. It accepts operand jobs over a valid/ready request port, loads the SNG with operands and a truncation mask, and restarts it with a clear pulse. It then counts the cycles in which all generated bits are 1, i.e. the SC product stream, until the SNG signals period end, and returns the count over a valid/ready response port. It sits between the accelerator's job dispatcher and a single SNG instance.

## Interface
- WIDTH, 4: bits per operand.
- NUM_INPUTS, 2: operands per job, which is also the SNG lane count.
- CW, derived = WIDTH*NUM_INPUTS+1: counter and result width.
- PW, derived = $clog2(WIDTH+1): precision field width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  job offered.
- req_ready  out  1  job accepted when valid&ready.
- req_bxs  in  WIDTH*NUM_INPUTS  operand i at [i*WIDTH +: WIDTH].
- req_prec  in  PW  kept MSBs per operand, 1..WIDTH. Values 0 or >WIDTH are treated as WIDTH.
- abort  in  1  level, sampled only in CLEAR/RUN.
- sng_clr_n  out  1  registered active-low restart to the SNG.
- sng_bxs  out  WIDTH*NUM_INPUTS  operands to the SNG, held constant for the whole job.
- sng_trunc  out  WIDTH  mask; bit k=1 for k < WIDTH-prec.
- sng_xs  in  NUM_INPUTS  SNG output bits.
- sng_done  in  1  SNG period-end flag, registered in the SNG.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when valid&ready.
- rsp_count  out  CW  number of counted cycles with &sng_xs=1.
- rsp_cycles  out  CW  stream length L, the number of counted cycles.
- rsp_status  out  2  0 = ok, 1 = aborted, 2 = timeout.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_bxs into sng_bxs.
  - Latch the decoded mask into sng_trunc.
  - Zero the count and cycle registers, then go to CLEAR.
- CLEAR, exactly 1 cycle:
  - sng_clr_n=0.
  - Nothing is counted.
  - Go to RUN. If abort=1, go to RESP with status 1 and zero counts instead.
- RUN, evaluated each cycle in this priority order:
  1. sng_done=1: do not count this cycle; status 0; go to RESP.
  2. abort=1: do not count this cycle; status 1; go to RESP.
  3. cycles==2^(WIDTH*NUM_INPUTS): status 2; go to RESP.
  4. Otherwise: cycles+=1, and count+=1 if &sng_xs.
- RESP:
  - rsp_valid=1, with rsp_count, rsp_cycles and rsp_status held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- Only one job is outstanding at a time. req_ready=0 in all states other than IDLE.
- sng_bxs and sng_trunc keep their last values in IDLE and do not change until the next accept.
- Counters are CW bits wide and never wrap, because timeout fires at 2^(WIDTH*NUM_INPUTS) before the counter can overflow.
- rsp_count ≤ rsp_cycles always.
- abort outside CLEAR/RUN is ignored.
- When sng_done and abort arrive in the same RUN cycle, sng_done wins and status is 0.

## Timing
- Accept in cycle T: CLEAR at T+1, and the first RUN cycle at T+2, where the SNG counter is 0.
- sng_done high in cycle D: rsp_valid=1 from D+1.
- A job is accepted at the earliest in the cycle after the response handshake, so there is one bubble between jobs.
- All outputs are registered. busy and req_ready are decoded from the state register.
- Reset values: state IDLE, req_ready=1, sng_clr_n=1, sng_bxs=0, sng_trunc=0, rsp_valid=0, rsp_count=0, rsp_cycles=0, rsp_status=0, busy=0.
- Reset mid-job:
  - The state machine returns to IDLE immediately and the partial result is discarded.
  - sng_clr_n=1. The SNG is reset by the same rst_n.

## Test plan
All scenarios use WIDTH=4 and NUM_INPUTS=2 with a behavioural SNG model.

1. Full precision: bxs={8,8}, prec=4 -> rsp_cycles=256, rsp_count=64, status 0, with rsp_valid asserted 259 cycles after accept.
2. Zero operand: bxs={15,0}, prec=4 -> rsp_count=0, rsp_cycles=256. Also bxs={15,15} -> rsp_count=225.
3. Early termination: bxs={8,4}, prec=2 -> sng_trunc=4'b0011, rsp_cycles<256, rsp_count*256 == rsp_cycles*32. Also prec=0 behaves as prec=4, with sng_trunc=0.
4. Abort: assert abort on RUN cycle k=10 -> status 1, rsp_cycles=10. Also: abort together with sng_done in the same cycle -> status 0. Also: abort in CLEAR -> status 1, counts 0.
5. Timeout: model holds sng_done=0 -> status 2, rsp_cycles=256, rsp_valid at accept+259.
6. Handshake and reset:
   - Hold rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0 throughout.
   - Issue back-to-back jobs -> second accept exactly one cycle after the response handshake.
   - Drop rst_n mid-RUN -> all outputs at their reset values, and the next job produces a correct result.
